control_sequencer: RTL and testbench

Hardwired control unit that drives the CPU datapath's control inputs. It sits directly upstream of `datapath` and replaces bench-driven T0–T5 sequencing with a synchronous Moore state machine. The machine fetches an instruction, decodes `ir[31:27]`, and steps through the execute cycles for R-format ALU, immediate ALU, MUL/DIV, NOP and HALT instructions. It also keeps a retired-instruction counter and a HALT/run indication.

---
 rtl/control_sequencer_if.sv | 33 +++
 rtl/control_sequencer.sv | 176 +++++++++++++++++
 tb/tb_control_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between control_sequencer (master) and the CPU datapath (slave).
// Carries the IR/memory status inputs and every datapath strobe the sequencer drives.
interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ir;
    logic             mem_ready;
    logic             PCout, ZHighout, ZLowout, HIout, LOout, MDRout;
    logic             MAR_enable, PC_enable, MDRin, mdr_read, IR_enable;
    logic             Yin, HIin, LOin, ZHigh_enable, ZLow_enable;
    logic             IncPC, Cout, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]       alu_op;
    logic             run, illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  ir, mem_ready,
        output PCout, ZHighout, ZLowout, HIout, LOout, MDRout,
               MAR_enable, PC_enable, MDRin, mdr_read, IR_enable,
               Yin, HIin, LOin, ZHigh_enable, ZLow_enable,
               IncPC, Cout, Gra, Grb, Grc, Rin, Rout,
               alu_op, run, illegal, instr_count
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, ZHighout, ZLowout, HIout, LOout, MDRout,
               MAR_enable, PC_enable, MDRin, mdr_read, IR_enable,
               Yin, HIin, LOin, ZHigh_enable, ZLow_enable,
               IncPC, Cout, Gra, Grb, Grc, Rin, Rout,
               alu_op, run, illegal, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch, decode ir[31:27], execute ALU/MULDIV/NOP/HALT.
// Optional macro CTRL_MEM_WAIT_EN stretches F1 until mem_ready is high.
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_F0    = 4'd1;
    localparam logic [3:0] S_F1    = 4'd2;
    localparam logic [3:0] S_F2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_HALT  = 4'd8;

    typedef enum logic [2:0] {C_ALU_R, C_ALU_I, C_MULDIV, C_NOP, C_HALT, C_UNDEF} op_class_t;

    logic [3:0]       state, state_next;
    logic [CNT_W-1:0] count;
    logic             retire;
    logic [4:0]       opcode;
    op_class_t        op_class;
    logic             unused_inputs;

    assign opcode = bus.ir[31:27];
    // Operand fields belong to the datapath; mem_ready is only consulted when waits are enabled.
    assign unused_inputs = ^{bus.ir[26:0], bus.mem_ready};

    always_comb begin
        if (opcode >= 5'h03 && opcode <= 5'h0B)      op_class = C_ALU_R;
        else if (opcode >= 5'h0C && opcode <= 5'h0E) op_class = C_ALU_I;
        else if (opcode == 5'h0F || opcode == 5'h10) op_class = C_MULDIV;
        else if (opcode == 5'h1A)                    op_class = C_NOP;
        else if (opcode == 5'h1B)                    op_class = C_HALT;
        else                                         op_class = C_UNDEF;
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_RESET: state_next = S_F0;
            S_F0:    state_next = S_F1;
`ifdef CTRL_MEM_WAIT_EN
            S_F1:    state_next = bus.mem_ready ? S_F2 : S_F1;
`else
            S_F1:    state_next = S_F2;
`endif
            S_F2:    state_next = S_T3;
            S_T3: begin
                case (op_class)
                    C_NOP:   begin state_next = S_F0;   retire = 1'b1; end
                    C_HALT:  begin state_next = S_HALT; retire = 1'b1; end
                    C_UNDEF: state_next = S_F0;
                    default: state_next = S_T4;
                endcase
            end
            S_T4:    state_next = S_T5;
            S_T5: begin
                if (op_class == C_MULDIV) begin
                    state_next = S_T6;
                end else begin
                    state_next = S_F0;
                    retire     = 1'b1;
                end
            end
            S_T6:    begin state_next = S_F0; retire = 1'b1; end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_RESET;
            count <= '0;
        end else begin
            state <= state_next;
            if (retire) count <= count + 1'b1;
        end
    end

    assign bus.instr_count = count;

    // NOTE: every strobe gets a default first so no path through the case infers a latch.
    always_comb begin
        bus.PCout        = 1'b0;
        bus.ZHighout     = 1'b0;
        bus.ZLowout      = 1'b0;
        bus.HIout        = 1'b0;
        bus.LOout        = 1'b0;
        bus.MDRout       = 1'b0;
        bus.MAR_enable   = 1'b0;
        bus.PC_enable    = 1'b0;
        bus.MDRin        = 1'b0;
        bus.mdr_read     = 1'b0;
        bus.IR_enable    = 1'b0;
        bus.Yin          = 1'b0;
        bus.HIin         = 1'b0;
        bus.LOin         = 1'b0;
        bus.ZHigh_enable = 1'b0;
        bus.ZLow_enable  = 1'b0;
        bus.IncPC        = 1'b0;
        bus.Cout         = 1'b0;
        bus.Gra          = 1'b0;
        bus.Grb          = 1'b0;
        bus.Grc          = 1'b0;
        bus.Rin          = 1'b0;
        bus.Rout         = 1'b0;
        bus.alu_op       = 5'd0;
        bus.illegal      = 1'b0;
        bus.run          = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_F0: begin
                bus.PCout       = 1'b1;
                bus.MAR_enable  = 1'b1;
                bus.IncPC       = 1'b1;
                bus.ZLow_enable = 1'b1;
            end
            S_F1: begin
                bus.mdr_read = 1'b1;
                bus.MDRin    = 1'b1;
`ifdef CTRL_MEM_WAIT_EN
                // PC advances only in the F1 cycle that completes the read.
                bus.ZLowout   = bus.mem_ready;
                bus.PC_enable = bus.mem_ready;
`else
                bus.ZLowout   = 1'b1;
                bus.PC_enable = 1'b1;
`endif
            end
            S_F2: begin
                bus.MDRout    = 1'b1;
                bus.IR_enable = 1'b1;
            end
            S_T3: begin
                if (op_class == C_ALU_R || op_class == C_ALU_I || op_class == C_MULDIV) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end
                bus.illegal = (op_class == C_UNDEF);
            end
            S_T4: begin
                bus.alu_op       = opcode;
                bus.ZLow_enable  = 1'b1;
                bus.ZHigh_enable = (op_class == C_MULDIV);
                if (op_class == C_ALU_I) begin
                    bus.Cout = 1'b1;
                end else begin
                    bus.Grc  = 1'b1;
                    bus.Rout = 1'b1;
                end
            end
            S_T5: begin
                bus.ZLowout = 1'b1;
                if (op_class == C_MULDIV) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end
            end
            S_T6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control words queued by the
// stimulus from opcode-class step tables, popped and compared by a negedge monitor.
module tb_control_sequencer;
    localparam int CNT_W = 8;

    localparam logic [29:0] K_PCOUT    = 30'h1 << 24;
    localparam logic [29:0] K_ZHIGHOUT = 30'h1 << 23;
    localparam logic [29:0] K_ZLOWOUT  = 30'h1 << 22;
    localparam logic [29:0] K_HIOUT    = 30'h1 << 21;
    localparam logic [29:0] K_LOOUT    = 30'h1 << 20;
    localparam logic [29:0] K_MDROUT   = 30'h1 << 19;
    localparam logic [29:0] K_MAREN    = 30'h1 << 18;
    localparam logic [29:0] K_PCEN     = 30'h1 << 17;
    localparam logic [29:0] K_MDRIN    = 30'h1 << 16;
    localparam logic [29:0] K_MDRREAD  = 30'h1 << 15;
    localparam logic [29:0] K_IREN     = 30'h1 << 14;
    localparam logic [29:0] K_YIN      = 30'h1 << 13;
    localparam logic [29:0] K_HIIN     = 30'h1 << 12;
    localparam logic [29:0] K_LOIN     = 30'h1 << 11;
    localparam logic [29:0] K_ZHIGHEN  = 30'h1 << 10;
    localparam logic [29:0] K_ZLOWEN   = 30'h1 << 9;
    localparam logic [29:0] K_INCPC    = 30'h1 << 8;
    localparam logic [29:0] K_COUT     = 30'h1 << 7;
    localparam logic [29:0] K_GRA      = 30'h1 << 6;
    localparam logic [29:0] K_GRB      = 30'h1 << 5;
    localparam logic [29:0] K_GRC      = 30'h1 << 4;
    localparam logic [29:0] K_RIN      = 30'h1 << 3;
    localparam logic [29:0] K_ROUT     = 30'h1 << 2;
    localparam logic [29:0] K_RUN      = 30'h1 << 1;
    localparam logic [29:0] K_ILLEGAL  = 30'h1;
    localparam logic [29:0] K_DRIVERS  = K_PCOUT | K_ZHIGHOUT | K_ZLOWOUT | K_HIOUT |
                                         K_LOOUT | K_MDROUT | K_COUT | K_ROUT;

    typedef enum {ALU_R, ALU_I, MULDIV, NOP, HLT, UNDEF} cls_e;

    typedef struct {
        logic [29:0]      word;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    logic clk;
    logic clear;
    control_sequencer_if #(.CNT_W(CNT_W)) bus ();

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    logic [29:0] act_word;
    assign act_word = {bus.alu_op, bus.PCout, bus.ZHighout, bus.ZLowout, bus.HIout, bus.LOout,
                       bus.MDRout, bus.MAR_enable, bus.PC_enable, bus.MDRin, bus.mdr_read,
                       bus.IR_enable, bus.Yin, bus.HIin, bus.LOin, bus.ZHigh_enable,
                       bus.ZLow_enable, bus.IncPC, bus.Cout, bus.Gra, bus.Grb, bus.Grc,
                       bus.Rin, bus.Rout, bus.run, bus.illegal};

    exp_t             exp_q[$];
    logic [CNT_W-1:0] model_count;
    int               n_checks;
    int               n_fail;
    bit               started;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, actual, expected);
        end
    endtask

    function automatic cls_e classify(input logic [4:0] op);
        if (op inside {[5'h03:5'h0B]}) return ALU_R;
        if (op inside {[5'h0C:5'h0E]}) return ALU_I;
        if (op inside {5'h0F, 5'h10})  return MULDIV;
        if (op == 5'h1A)               return NOP;
        if (op == 5'h1B)               return HLT;
        return UNDEF;
    endfunction

    // Monitor: one expectation per cycle, plus the single-bus-driver invariant.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, 64'({act_word, bus.instr_count}), 64'({e.word, e.cnt}));
        end
        if (started)
            check("one_bus_driver", 64'($countones(act_word & K_DRIVERS) <= 1), 64'd1);
    end

    // Queue what the current cycle must show, then advance to just after the next edge.
    task automatic expect_cycle(input logic [29:0] w, input string tag);
        exp_t e;
        e.word = w;
        e.cnt  = model_count;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after clear was sampled high: the DUT sits in RESET.
    task automatic enter_reset(input int hold);
        model_count = '0;
        for (int i = 0; i < hold; i++) expect_cycle(30'd0, "reset_hold");
        clear = 1'b0;
        expect_cycle(30'd0, "reset_exit");
    endtask

    task automatic run_instr(input logic [31:0] instr, input int wait_cycles, input bit abort_t4);
        cls_e        c;
        logic [29:0] alu;
        logic [29:0] t4;
        c   = classify(instr[31:27]);
        alu = 30'(instr[31:27]) << 25;
        bus.ir = instr;
        expect_cycle(K_RUN | K_PCOUT | K_MAREN | K_INCPC | K_ZLOWEN, "F0");
`ifdef CTRL_MEM_WAIT_EN
        for (int i = 0; i < wait_cycles; i++) begin
            bus.mem_ready = 1'b0;
            expect_cycle(K_RUN | K_MDRIN | K_MDRREAD, "F1_wait");
        end
        bus.mem_ready = 1'b1;
`else
        bus.mem_ready = 1'($urandom_range(0, 1));
        if (wait_cycles < 0) bus.mem_ready = 1'b0;
`endif
        expect_cycle(K_RUN | K_ZLOWOUT | K_PCEN | K_MDRREAD | K_MDRIN, "F1");
        expect_cycle(K_RUN | K_MDROUT | K_IREN, "F2");
        case (c)
            NOP: begin
                expect_cycle(K_RUN, "T3_nop");
                model_count = model_count + 1'b1;
            end
            HLT: begin
                expect_cycle(K_RUN, "T3_halt");
                model_count = model_count + 1'b1;
            end
            UNDEF: expect_cycle(K_RUN | K_ILLEGAL, "T3_undef");
            default: begin
                expect_cycle(K_RUN | K_GRB | K_ROUT | K_YIN, "T3");
                t4 = K_RUN | alu | K_ZLOWEN |
                     ((c == ALU_I) ? K_COUT : (K_GRC | K_ROUT)) |
                     ((c == MULDIV) ? K_ZHIGHEN : 30'd0);
                if (abort_t4) begin
                    clear = 1'b1;
                    expect_cycle(t4, "T4_abort");
                    enter_reset(1);
                end else begin
                    expect_cycle(t4, "T4");
                    if (c == MULDIV) begin
                        expect_cycle(K_RUN | K_ZLOWOUT | K_LOIN, "T5_muldiv");
                        expect_cycle(K_RUN | K_ZHIGHOUT | K_HIIN, "T6");
                    end else begin
                        expect_cycle(K_RUN | K_ZLOWOUT | K_GRA | K_RIN, "T5_alu");
                    end
                    model_count = model_count + 1'b1;
                end
            end
        endcase
    endtask

    initial begin : stimulus
        logic [31:0] instr;
        n_checks      = 0;
        n_fail        = 0;
        started       = 1'b0;
        model_count   = '0;
        clear         = 1'b1;
        bus.ir        = 32'd0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        enter_reset(3);

        run_instr(32'h2A2B8000, 0, 1'b0);
        run_instr({5'h0F, 27'($urandom)}, 1, 1'b0);
        run_instr({5'h1B, 27'($urandom)}, 0, 1'b0);
        for (int i = 0; i < 19; i++) expect_cycle(30'd0, "halt");
        clear = 1'b1;
        expect_cycle(30'd0, "halt_clear");
        enter_reset(1);

        run_instr({5'h1F, 27'($urandom)}, 0, 1'b0);
        run_instr({5'h0D, 27'($urandom)}, 3, 1'b0);
        run_instr({5'h10, 27'($urandom)}, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            instr = $urandom;
            if (instr[31:27] == 5'h1B) instr[31:27] = 5'h1A;
            run_instr(instr, int'($urandom_range(0, 2)), 1'b0);
        end

        run_instr({5'h07, 27'($urandom)}, 0, 1'b1);

        // Counter starts from zero after the abort; 2**CNT_W NOPs must wrap it back to zero.
        for (int i = 0; i < (1 << CNT_W); i++) run_instr({5'h1A, 27'($urandom)}, 0, 1'b0);
        run_instr({5'h03, 27'($urandom)}, 0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
